// File: rtl/bclg4_seq_pkg.sv
// Shared types and helpers for the nibble-serial BCLG4 adder sequencer.
package bclg4_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

  localparam int NIB_BITS = 4;

  function automatic int nib_idx_w(input int width);
    return $clog2(width / NIB_BITS);
  endfunction

endpackage

// File: rtl/bclg4_serial_add_ctrl_bclg4.sv
// BCLG4: 4-bit carry-lookahead slice with group propagate/generate outputs.
module BCLG4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Pout,
  output logic       Gout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = A ^ B;
  assign g = A & B;

  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);

  assign S    = p ^ c;
  assign Pout = &p;
  assign Gout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/bclg4_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder reusing one BCLG4 slice, LSB nibble first.
// Define BCLG4_OVF_EN to add the signed-overflow output ovf.
module bclg4_serial_add_ctrl
  import bclg4_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef BCLG4_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = WIDTH / NIB_BITS;
  localparam int IDX_W = nib_idx_w(WIDTH);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
      $fatal(1, "bclg4_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  seq_state_t state, state_nxt;

  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [NIB_BITS-1:0] s;
  logic                pout;
  logic                gout;
  logic                carry_nxt;
  logic                last;

  BCLG4 u_slice (
    .A    (a_q[NIB_BITS*idx +: NIB_BITS]),
    .B    (b_q[NIB_BITS*idx +: NIB_BITS]),
    .Cin  (carry),
    .S    (s),
    .Pout (pout),
    .Gout (gout)
  );

  assign carry_nxt = gout | (pout & carry);
  assign last      = (idx == IDX_W'(NIB - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last)     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef BCLG4_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b;
          carry <= cin;
          idx   <= '0;
`ifdef BCLG4_OVF_EN
          ovf   <= 1'b0;
`endif
        end
        RUN: begin
          sum[NIB_BITS*idx +: NIB_BITS] <= s;
          carry <= carry_nxt;
          if (last) begin
            cout <= carry_nxt;
            idx  <= '0;
`ifdef BCLG4_OVF_EN
            // s[3] is the final sum MSB, still combinational on this edge
            ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s[3] != a_q[WIDTH-1]);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bclg4_serial_add_ctrl.sv
// Scoreboard bench for bclg4_serial_add_ctrl (WIDTH=16); ovf checked when BCLG4_OVF_EN is defined.
module tb_bclg4_serial_add_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef BCLG4_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bclg4_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef BCLG4_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    exp_t        e;
    logic [W:0]  full;
    full   = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, xc};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (xa[W-1] == xb[W-1]) && (full[W-1] != xa[W-1]);
    return e;
  endfunction

  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc, input int hold);
    exp_t e;
    int   cyc;
    @(negedge clk);
    check("accept_in_ready", in_ready, 1);
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    out_ready = (hold == 0);
    sb.push_back(model(xa, xb, xc));
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    check("run_busy", busy, 1);
    check("run_in_ready", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, 4);
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    check("sum", sum, e.sum);
    check("cout", cout, e.cout);
`ifdef BCLG4_OVF_EN
    check("ovf", ovf, e.ovf);
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_sum", sum, e.sum);
      check("hold_cout", cout, e.cout);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("handoff_in_ready", in_ready, 1);
    check("handoff_out_valid", out_valid, 0);
    check("handoff_busy", busy, 0);
  endtask

  task automatic do_abort(input logic [W-1:0] xa, input logic [W-1:0] xb);
    int vcount;
    @(negedge clk);
    a = xa; b = xb; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    vcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("abort_no_valid", vcount, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
`ifdef BCLG4_OVF_EN
    check("rst_ovf", ovf, 0);
`endif

    do_op(16'h00FF, 16'h0001, 1'b0, 0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 0);
    do_op(16'h5555, 16'hAAAA, 1'b0, 3);
    do_abort(16'h1234, 16'h1111);
    do_op(16'h7FFF, 16'h0001, 1'b0, 0);
    do_op(16'h0003, 16'h000D, 1'b0, 0);
    do_op(16'h8000, 16'h8000, 1'b1, 1);
    for (int i = 0; i < 6; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), i % 2);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
